// File: rtl/wb_result_queue.sv
// Write-back FIFO from the ALU result path to the register bank.
// Define WB_RESULT_QUEUE_BYPASS_EN for a zero-latency path when empty.
module wb_result_queue #(
    parameter int DEPTH    = 4,
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 32,
    localparam int IDX_W   = $clog2(NUM_REGS),
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [IDX_W-1:0]    in_dest,
    input  logic                stall,
    output logic [NUM_REGS-1:0] we,
    output logic [DATA_W-1:0]   wr_data,
    output logic [CNT_W-1:0]    count,
    output logic                bad_dest
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [IDX_W-1:0]  dest_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              empty;
    logic              accept;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  sel_dest;
    logic              sel_en;

    assign empty    = (count == '0);
    assign in_ready = (count != CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;

`ifdef WB_RESULT_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid && !stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result is written straight through and never stored.
    assign push = accept && !bypass;
    assign pop  = !empty && !stall;

    always_comb begin
        sel_dest = dest_q[rd_ptr];
        sel_en   = pop;
        wr_data  = empty ? '0 : data_q[rd_ptr];
        if (bypass) begin
            sel_dest = in_dest;
            sel_en   = 1'b1;
            wr_data  = in_data;
        end
        // Out-of-range indices match no bit, so they drain silently.
        we = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            we[i] = sel_en && (sel_dest == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= in_data;
            dest_q[wr_ptr] <= in_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            bad_dest <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && (int'(in_dest) >= NUM_REGS)) begin
                bad_dest <= 1'b1;
            end
        end
    end

endmodule
